// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program into instruction memory
// and holds the CPU in reset until the load finishes cleanly.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    BYTE,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int PADW = 16 - ADDR_W;
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t          state;
  state_t          nxt;
  logic [15:0]     count;
  logic [1:0]      bidx;
  logic [ADDR_W:0] widx;
  logic [ADDR_W:0] widx_inc;
  logic [31:0]     asm_q;
  logic [16:0]     n_new;
  logic            xfer;
  logic            last_word;

  assign xfer      = in_valid & in_ready;
  assign n_new     = {1'b0, count[15:8], in_data};
  assign widx_inc  = widx + {{ADDR_W{1'b0}}, 1'b1};
  // widx is ADDR_W+1 bits so a full-depth program ends without wrap
  assign last_word = {{PADW{1'b0}}, widx_inc} == {1'b0, count};

  always_comb begin
    nxt = state;
    unique case (state)
      CNT_HI: if (xfer) nxt = CNT_LO;
      CNT_LO: begin
        if (xfer) begin
          if (n_new == 17'd0)
            nxt = DONE;
          else if (n_new > DEPTH)
            nxt = ERR;
          else
            nxt = BYTE;
        end
      end
      BYTE:   if (xfer && bidx == 2'd3) nxt = WRITE;
      WRITE:  nxt = last_word ? DONE : BYTE;
      DONE:   if (restart) nxt = CNT_HI;
      ERR:    if (restart) nxt = CNT_HI;
      default: nxt = CNT_HI;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CNT_HI;
      count     <= '0;
      bidx      <= '0;
      widx      <= '0;
      asm_q     <= '0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
      in_ready  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_reset <= 1'b0;
    end else begin
      state     <= nxt;
      in_ready  <= (nxt == CNT_HI) || (nxt == CNT_LO) || (nxt == BYTE);
      im_we     <= (nxt == WRITE);
      done      <= (nxt == DONE);
      err       <= (nxt == ERR);
      cpu_reset <= (nxt == DONE);
      unique case (state)
        CNT_HI: if (xfer) count[15:8] <= in_data;
        CNT_LO: begin
          if (xfer) begin
            count[7:0] <= in_data;
            bidx       <= '0;
            widx       <= '0;
          end
        end
        BYTE: begin
          if (xfer) begin
            asm_q <= {asm_q[23:0], in_data};
            bidx  <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              im_addr  <= widx[ADDR_W-1:0];
              im_wdata <= {asm_q[23:0], in_data};
            end
          end
        end
        WRITE: begin
          widx <= widx_inc;
          bidx <= '0;
        end
        DONE, ERR: begin
          if (restart) begin
            count <= '0;
            bidx  <= '0;
            widx  <= '0;
            asm_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized program loads checked
// against a word-list reference model built from the stream rules.
module tb_imem_loader;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          restart;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_reset;
  logic          done;
  logic          err;

  always #5 clock = ~clock;

  imem_loader #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .restart(restart),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // write monitor: every strobe is logged and must follow a byte transfer
  int cyc = 0;
  int we_cyc = -10;
  int xfer_cyc = -10;
  int done_cyc = -1;
  bit dprev = 1'b0;
  logic [AW-1:0] rq_addr[$];
  logic [31:0]   rq_data[$];

  always @(negedge clock) begin
    cyc++;
    if (im_we === 1'b1) begin
      rq_addr.push_back(im_addr);
      rq_data.push_back(im_wdata);
      chk("we_latency", 32'(cyc - xfer_cyc), 32'd1);
      we_cyc = cyc;
    end
    if (in_valid === 1'b1 && in_ready === 1'b1 && reset === 1'b0)
      xfer_cyc = cyc;
    if (done === 1'b1 && !dprev) done_cyc = cyc;
    dprev = (done === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    repeat (g) begin
      @(posedge clock); #1;
      in_valid = 1'b0;
    end
    @(posedge clock); #1;
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 100 && !in_ready; n++) begin
      @(posedge clock); #1;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic finish_stream();
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (done || err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_restart();
    @(posedge clock); #1;
    restart = 1'b1;
    @(posedge clock); #1;
    restart = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clock);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_we"}, 32'(im_we), 32'd0);
  endtask

  typedef struct {
    int n;
    int gap;
    bit fixed;
    bit exp_done;
    bit exp_err;
    int exp_writes;
  } vec_t;

  vec_t        tbl[$];
  vec_t        v;
  logic [31:0] words[$];
  logic [31:0] fixedw[2];
  bit          ok;
  int          rn;

  initial begin
    fixedw[0] = 32'h24010005;
    fixedw[1] = 32'hAC010000;
    tbl.push_back('{2, 0, 1'b1, 1'b1, 1'b0, 2});
    tbl.push_back('{2, 3, 1'b1, 1'b1, 1'b0, 2});
    tbl.push_back('{0, 0, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{1025, 0, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1024, 0, 1'b0, 1'b1, 1'b0, 1024});
    tbl.push_back('{1, 0, 1'b0, 1'b1, 1'b0, 1});
    for (int r = 0; r < 4; r++) begin
      rn = int'($urandom_range(1, 8));
      tbl.push_back('{rn, -1, 1'b0, 1'b1, 1'b0, rn});
    end
    tbl.push_back('{65535, 0, 1'b0, 1'b0, 1'b1, 0});

    reset = 1'b1;
    restart = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(im_we), 32'd0);
    chk("rst_addr", 32'(im_addr), 32'd0);
    chk("rst_wdata", im_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cpurst", 32'(cpu_reset), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      words.delete();
      if (!v.exp_err)
        for (int k = 0; k < v.n; k++)
          words.push_back(v.fixed ? fixedw[k] : $urandom());
      rq_addr.delete();
      rq_data.delete();
      send_byte(v.n[15:8], v.gap);
      send_byte(v.n[7:0], v.gap);
      foreach (words[k]) send_word(words[k], v.gap);
      finish_stream();
      wait_end(ok);
      chk("end_reached", 32'(ok), 32'd1);
      repeat (3) @(negedge clock);
      chk("vec_done", 32'(done), 32'(v.exp_done));
      chk("vec_err", 32'(err), 32'(v.exp_err));
      chk("vec_cpurst", 32'(cpu_reset), 32'(v.exp_done));
      chk("vec_ready", 32'(in_ready), 32'd0);
      chk("vec_nwrites", 32'(rq_addr.size()), 32'(v.exp_writes));
      for (int k = 0; k < rq_addr.size() && k < v.exp_writes; k++) begin
        chk("wr_addr", 32'(rq_addr[k]), 32'(k));
        chk("wr_data", rq_data[k], words[k]);
      end
      if (v.exp_writes > 0)
        chk("done_after_we", 32'(done_cyc - we_cyc), 32'd1);
      pulse_restart();
      check_idle("restart");
    end

    // restart held through most of a load must be ignored
    rq_addr.delete();
    rq_data.delete();
    restart = 1'b1;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    restart = 1'b0;
    send_byte(8'hEF, 0);
    finish_stream();
    wait_end(ok);
    repeat (2) @(negedge clock);
    chk("rs_done", 32'(done), 32'd1);
    chk("rs_nwrites", 32'(rq_addr.size()), 32'd1);
    if (rq_addr.size() > 0) begin
      chk("rs_addr", 32'(rq_addr[0]), 32'd0);
      chk("rs_data", rq_data[0], 32'hDEADBEEF);
    end
    pulse_restart();
    check_idle("rs_idle");

    // reset after two of three words, then a fresh one-word load
    rq_addr.delete();
    rq_data.delete();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_word(32'h11223344, 0);
    send_word(32'h55667788, 0);
    finish_stream();
    for (int n = 0; n < 20 && rq_addr.size() < 2; n++) @(negedge clock);
    chk("mid_nwrites", 32'(rq_addr.size()), 32'd2);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("mr_ready", 32'(in_ready), 32'd1);
    chk("mr_we", 32'(im_we), 32'd0);
    chk("mr_addr", 32'(im_addr), 32'd0);
    chk("mr_wdata", im_wdata, 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    chk("mr_cpurst", 32'(cpu_reset), 32'd0);
    rq_addr.delete();
    rq_data.delete();
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    send_word(32'hCAFEF00D, 2);
    finish_stream();
    wait_end(ok);
    repeat (2) @(negedge clock);
    chk("mr2_done", 32'(done), 32'd1);
    chk("mr2_nwrites", 32'(rq_addr.size()), 32'd1);
    if (rq_addr.size() > 0) begin
      chk("mr2_addr", 32'(rq_addr[0]), 32'd0);
      chk("mr2_data", rq_data[0], 32'hCAFEF00D);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, 10, instruction-memory word-address width; depth = 2**ADDR_W words.
REQ-002 Port: clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  loader byte stream: byte present.
REQ-005 Port: in_data  input  8  loader byte stream: byte value.
REQ-006 Port: in_ready  output  1  loader can accept a byte this cycle; transfer = in_valid & in_ready at rising edge.
REQ-007 Port: restart  input  1  single-cycle request to reload a new program; honoured only in DONE or ERR.
REQ-008 Port: im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 Port: im_addr  output  ADDR_W  instruction-memory word address.
REQ-010 Port: im_wdata  output  32  instruction word to write.
REQ-011 Port: cpu_reset  output  1  active-low reset to the CPU; 0 while loading or in error, 1 only in DONE.
REQ-012 Port: done  output  1  program loaded successfully.
REQ-013 Port: err  output  1  header word count exceeds memory depth.

Function
REQ-014 Stream format: 2-byte word count N (MSB first), then N words of 4 bytes each, MSB first.
REQ-015 States: CNT_HI, CNT_LO, BYTE, WRITE, DONE, ERR.
REQ-016 in_ready = 1 in CNT_HI, CNT_LO, BYTE; 0 in WRITE, DONE, ERR.
REQ-017 CNT_HI: on transfer latch count[15:8], go CNT_LO; CNT_LO: on transfer latch count[7:0].
REQ-018 Leaving CNT_LO: N = 0 -> DONE; N > 2**ADDR_W -> ERR; otherwise -> BYTE with byte index 0, word index 0.
REQ-019 BYTE: each transfer shifts in_data into the assembly register (first byte ends in bits [31:24]); transfer of byte index 3 -> WRITE.
REQ-020 WRITE lasts exactly one cycle: im_we = 1, im_addr = word index, im_wdata = assembled word; im_we = 0 in every other state.
REQ-021 After WRITE: word index + 1; if it now equals N -> DONE, else -> BYTE with byte index 0.
REQ-022 Latency: the im_we cycle immediately follows the edge accepting the 4th byte; done rises the cycle after the last im_we.
REQ-023 Cycles with in_valid = 0 in BYTE/CNT states hold all state; gaps of any length are allowed.
REQ-024 Word index is ADDR_W+1 bits wide internally so N = 2**ADDR_W completes without wrap; im_addr never exceeds 2**ADDR_W-1.
REQ-025 done = 1 only in DONE; err = 1 only in ERR; cpu_reset = 1 only in DONE.
REQ-026 restart in DONE or ERR -> CNT_HI next cycle, clearing done, err, and counters; cpu_reset drops to 0 that same cycle; restart in other states is ignored.
REQ-027 Bytes presented while in_ready = 0 are not consumed and have no effect.

Reset
REQ-028 reset = 1 at a rising edge forces state CNT_HI, counters and assembly register 0, im_we = 0, im_addr = 0, im_wdata = 0, done = 0, err = 0, cpu_reset = 0, in_ready = 1 after the edge.
REQ-029 reset has priority over restart and over any in-flight transfer; a partially loaded program is abandoned and already written words remain in memory.

Verification
REQ-030 Stream 00 02 | 24 01 00 05 | AC 01 00 00, in_valid held 1 -> im_we at addr 0 data 24010005, then addr 1 data AC010000; done = 1, cpu_reset = 1 one cycle later.
REQ-031 Same stream with in_valid deasserted 3 cycles between every byte -> identical writes and data; no extra im_we.
REQ-032 Stream 00 00 -> DONE directly after 2nd byte, no im_we, done = 1, cpu_reset = 1.
REQ-033 ADDR_W = 10, header 04 01 (1025) -> err = 1, done = 0, cpu_reset = 0, no im_we, in_ready = 0; header 04 00 with 1024 words -> last write at addr 3FF, done = 1.
REQ-034 reset asserted after 2 of 3 words written -> all outputs at reset values next cycle; new full 1-word stream then writes addr 0 and reaches done.
REQ-035 restart pulse in DONE -> CNT_HI, done = 0, cpu_reset = 0 next cycle; restart asserted mid-load -> ignored, load completes normally.
